// File: rtl/aibcr3_fine_dly_gray_ctrl.sv
// Fine-delay gray-code stepper: walks cur_bin toward the latched target one LSB per update,
// with a settle window after each code_valid strobe. AIBCR3_FINE_DLY_DIRECT_EN adds a direct-load jump.
module aibcr3_fine_dly_gray_ctrl #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter logic [2:0]  CODE_RST   = 3'd0
) (
  input  logic       ck,
  input  logic       nrst,
  input  logic       en,
  input  logic [2:0] target,
  input  logic       target_vld,
`ifdef AIBCR3_FINE_DLY_DIRECT_EN
  input  logic       direct_ld,
`endif
  output logic [2:0] gray,
  output logic       code_valid,
  output logic [2:0] cur_bin,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, STEP, LOAD, SETTLE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [2:0] tgt_q;
  logic [3:0] cnt;
  logic       up_q;
  logic       jump_q;
  logic       vld_q;
  logic       jump_req;

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

`ifdef AIBCR3_FINE_DLY_DIRECT_EN
  assign jump_req = target_vld & direct_ld & en;
`else
  assign jump_req = 1'b0;
`endif

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cur_bin    <= CODE_RST;
      gray       <= bin2gray(CODE_RST);
      tgt_q      <= CODE_RST;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      up_q       <= 1'b0;
      jump_q     <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      done       <= 1'b0;
      vld_q      <= target_vld;
      if (target_vld) tgt_q <= target;

      case (state)
        IDLE: begin
          // direct jump takes its code from tgt_q, which loads on this same edge
          if (jump_req) begin
            state  <= STEP;
            busy   <= 1'b1;
            jump_q <= 1'b1;
          end else if (en && (tgt_q != cur_bin)) begin
            state  <= STEP;
            busy   <= 1'b1;
            up_q   <= (tgt_q > cur_bin);
            jump_q <= 1'b0;
          end else if (vld_q && (tgt_q == cur_bin)) begin
            done <= 1'b1;
          end
        end

        STEP: begin
          if (jump_q) begin
            cur_bin <= tgt_q;
            gray    <= bin2gray(tgt_q);
          end else if (up_q) begin
            cur_bin <= cur_bin + 3'd1;
            gray    <= bin2gray(cur_bin + 3'd1);
          end else begin
            cur_bin <= cur_bin - 3'd1;
            gray    <= bin2gray(cur_bin - 3'd1);
          end
          state <= LOAD;
        end

        LOAD: begin
          code_valid <= 1'b1;
          cnt        <= SETTLE_LD;
          jump_q     <= 1'b0;
          state      <= SETTLE;
        end

        SETTLE: begin
          // a target update coinciding with expiry holds here one extra cycle so the compare sees it
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (target_vld) begin
            state <= SETTLE;
          end else if (en && (tgt_q != cur_bin)) begin
            state <= STEP;
            up_q  <= (tgt_q > cur_bin);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= (tgt_q == cur_bin);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
